// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between N_REQ producers, the round-robin arbiter and the FIFO write port.
// master: the arbiter's view; slave: the producers/FIFO side.
interface fifo_wr_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_last;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_ready;
    logic                   fifo_full;
    logic                   fifo_wr_en;
    logic [WIDTH-1:0]       fifo_wr_data;
    logic                   grant_valid;
    logic [IDW-1:0]         grant_id;
    logic [15:0]            word_count;

    modport master (
        input  req_valid, req_last, req_data, fifo_full,
        output req_ready, fifo_wr_en, fifo_wr_data, grant_valid, grant_id, word_count
    );

    modport slave (
        output req_valid, req_last, req_data, fifo_full,
        input  req_ready, fifo_wr_en, fifo_wr_data, grant_valid, grant_id, word_count
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers, with bounded
// bursts per grant, FIFO-full back-pressure and a wrapping written-word counter.
module fifo_wr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 4,
    parameter int IDW       = $clog2(N_REQ)
) (
    input  logic            clk,
    input  logic            rst,
    fifo_wr_arbiter_if.master bus
);
    localparam int BCW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic {ARB, GRANT} state_t;

    state_t           state_reg;
    logic             grant_valid_reg;
    logic [IDW-1:0]   grant_id_reg;
    logic [IDW-1:0]   last_owner_reg;
    logic [BCW-1:0]   beat_cnt_reg;
    logic [15:0]      word_count_reg;

    logic [WIDTH-1:0] data_slice [N_REQ];
    logic             owner_valid;
    logic             owner_last;
    logic             accept;
    logic             burst_done;
    logic             pick_found;
    logic [IDW-1:0]   pick_id;
    int               idx;
    logic [IDW-1:0]   idx_w;

    // Ready is gated by rst so a burst in flight cannot write during the reset cycle.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            assign data_slice[gi]    = bus.req_data[gi*WIDTH +: WIDTH];
            assign bus.req_ready[gi] = ~rst && (state_reg == GRANT) &&
                                       (grant_id_reg == IDW'(gi)) && ~bus.fifo_full;
        end
    endgenerate

    assign owner_valid = bus.req_valid[grant_id_reg];
    assign owner_last  = bus.req_last[grant_id_reg];
    assign accept      = owner_valid & bus.req_ready[grant_id_reg];
    assign burst_done  = owner_last | (beat_cnt_reg == BCW'(MAX_BURST - 1));

    assign bus.fifo_wr_en   = accept;
    assign bus.fifo_wr_data = data_slice[grant_id_reg];
    assign bus.grant_valid  = grant_valid_reg;
    assign bus.grant_id     = grant_id_reg;
    assign bus.word_count   = word_count_reg;

    // Search starts just after the previous owner, so the last winner has lowest priority.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        idx        = 0;
        idx_w      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(last_owner_reg) + 1 + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            idx_w = IDW'(idx);
            if (!pick_found && bus.req_valid[idx_w]) begin
                pick_found = 1'b1;
                pick_id    = idx_w;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ARB;
            grant_valid_reg <= 1'b0;
            grant_id_reg    <= '0;
            beat_cnt_reg    <= '0;
            last_owner_reg  <= IDW'(N_REQ - 1);
            word_count_reg  <= '0;
        end else begin
            if (accept) word_count_reg <= word_count_reg + 16'd1;
            unique case (state_reg)
                ARB: begin
                    if (pick_found) begin
                        state_reg       <= GRANT;
                        grant_valid_reg <= 1'b1;
                        grant_id_reg    <= pick_id;
                        beat_cnt_reg    <= '0;
                    end
                end
                GRANT: begin
                    // An owner that drops valid gives up the grant even while the FIFO is full.
                    if (!owner_valid || (accept && burst_done)) begin
                        state_reg       <= ARB;
                        grant_valid_reg <= 1'b0;
                        last_owner_reg  <= grant_id_reg;
                    end else if (accept) begin
                        beat_cnt_reg <= beat_cnt_reg + BCW'(1);
                    end
                end
                default: state_reg <= ARB;
            endcase
        end
    end
endmodule
